// File: rtl/wb_arbiter_pkg.sv
// Writeback arbiter shared types: ALU writeback bundle, requester bundle,
// requester slot indices and the x0 write-enable helper.
package wb_arbiter_pkg;

  typedef struct packed {
    logic        do_branch;
    logic [31:0] branch_target;
    logic        icache_invalidate;
    logic        register_write;
    logic [4:0]  rd;
    logic [31:0] exe_result;
  } alu_wb_inf_t;

  typedef struct packed {
    logic        register_write;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  localparam int WB_REQ_MUL = 0;
  localparam int WB_REQ_DIV = 1;
  localparam int WB_REQ_LSU = 2;

  // x0 is hardwired to zero, so a write to it is dropped.
  function automatic logic wb_we(
    input logic       we,
    input logic [4:0] rd
  );
    return we && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: i_req request vector, i_ptr search start index,
//        o_grant one-hot grant, o_idx grant index, o_any any grant.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PW-1:0]      o_idx,
  output logic               o_any
);

  int   w_i;
  logic w_found;

  // Walk from i_ptr upward with wrap; first requester wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_i     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_i = int'(i_ptr) + off;
      if (w_i >= NUM_REQ) w_i = w_i - NUM_REQ;
      if (!w_found && i_req[w_i]) begin
        w_found       = 1'b1;
        o_grant[w_i]  = 1'b1;
        o_idx         = PW'(w_i);
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback slot arbiter: ALU has priority, long-latency units share the
// leftover slots round-robin, and a starvation counter stalls IX issue.
// Ports: clk/rst; alu_valid, alu_wb_inf; req_valid/req_reg_write/req_rd/
//        req_data in, req_ready out; wb_* registered writeback; ix_stall.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  alu_wb_inf_t           alu_wb_inf,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_reg_write,
  input  logic [5*NUM_REQ-1:0]  req_rd,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  wb_reg_write,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_result,
  output logic                  wb_do_branch,
  output logic [31:0]           wb_branch_target,
  output logic                  wb_icache_invalidate,
  output logic                  ix_stall
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0]      r_rr_ptr;
  logic [CW-1:0]      r_starve_cnt;
  logic               r_ix_stall;
  logic               r_wb_reg_write;
  logic [4:0]         r_wb_rd;
  logic [31:0]        r_wb_result;
  logic               r_wb_do_branch;
  logic [31:0]        r_wb_branch_target;
  logic               r_wb_icache_inv;

  logic [NUM_REQ-1:0] w_grant;
  logic [PW-1:0]      w_idx;
  logic               w_any;
  logic               w_xfer;
  logic               w_pending;
  logic [PW-1:0]      w_ptr_nxt;
  wb_req_t            w_sel;
  int                 w_i;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Ready is withheld during reset so no transfer is accepted
  // while the writeback state is being cleared.
  assign req_ready = (alu_valid || rst) ? '0 : w_grant;
  assign w_xfer    = w_any && !alu_valid;
  assign w_pending = (|req_valid) && alu_valid;

  always_comb begin
    w_i                  = int'(w_idx);
    w_sel.register_write = req_reg_write[w_i];
    w_sel.rd             = req_rd[5*w_i +: 5];
    w_sel.data           = req_data[32*w_i +: 32];
    if (w_i + 1 >= NUM_REQ) w_ptr_nxt = '0;
    else                    w_ptr_nxt = PW'(w_i + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr           <= '0;
      r_starve_cnt       <= '0;
      r_ix_stall         <= 1'b0;
      r_wb_reg_write     <= 1'b0;
      r_wb_rd            <= '0;
      r_wb_result        <= '0;
      r_wb_do_branch     <= 1'b0;
      r_wb_branch_target <= '0;
      r_wb_icache_inv    <= 1'b0;
    end else begin
      if (alu_valid) begin
        r_wb_reg_write     <= wb_we(alu_wb_inf.register_write,
                                    alu_wb_inf.rd);
        r_wb_rd            <= alu_wb_inf.rd;
        r_wb_result        <= alu_wb_inf.exe_result;
        r_wb_do_branch     <= alu_wb_inf.do_branch;
        r_wb_branch_target <= alu_wb_inf.branch_target;
        r_wb_icache_inv    <= alu_wb_inf.icache_invalidate;
      end else if (w_xfer) begin
        r_wb_reg_write     <= wb_we(w_sel.register_write, w_sel.rd);
        r_wb_rd            <= w_sel.rd;
        r_wb_result        <= w_sel.data;
        r_wb_do_branch     <= 1'b0;
        r_wb_icache_inv    <= 1'b0;
        r_rr_ptr           <= w_ptr_nxt;
      end else begin
        r_wb_reg_write     <= 1'b0;
        r_wb_do_branch     <= 1'b0;
        r_wb_icache_inv    <= 1'b0;
      end

      if (w_pending) begin
        if (r_starve_cnt != CW'(STARVE_LIMIT))
          r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end

      // Stall stays up while the ALU keeps winning; it drops once a
      // long-latency result gets through or nobody is waiting.
      if (w_xfer || !(|req_valid))
        r_ix_stall <= 1'b0;
      else if (w_pending && r_starve_cnt >= CW'(STARVE_LIMIT - 1))
        r_ix_stall <= 1'b1;
    end
  end

  assign wb_reg_write         = r_wb_reg_write;
  assign wb_rd                = r_wb_rd;
  assign wb_result            = r_wb_result;
  assign wb_do_branch         = r_wb_do_branch;
  assign wb_branch_target     = r_wb_branch_target;
  assign wb_icache_invalidate = r_wb_icache_inv;
  assign ix_stall             = r_ix_stall;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter.
// Drives on the falling edge, samples 1 time unit after edges.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  alu_wb_inf_t alu_wb_inf;
  logic [2:0]  req_valid;
  logic [2:0]  req_reg_write;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        wb_do_branch;
  logic [31:0] wb_branch_target;
  logic        wb_icache_invalidate;
  logic        ix_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_REQ(3), .STARVE_LIMIT(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .alu_valid            (alu_valid),
    .alu_wb_inf           (alu_wb_inf),
    .req_valid            (req_valid),
    .req_reg_write        (req_reg_write),
    .req_rd               (req_rd),
    .req_data             (req_data),
    .req_ready            (req_ready),
    .wb_reg_write         (wb_reg_write),
    .wb_rd                (wb_rd),
    .wb_result            (wb_result),
    .wb_do_branch         (wb_do_branch),
    .wb_branch_target     (wb_branch_target),
    .wb_icache_invalidate (wb_icache_invalidate),
    .ix_stall             (ix_stall)
  );

  task automatic clear_inputs();
    alu_valid     = 1'b0;
    alu_wb_inf    = '0;
    req_valid     = '0;
    req_reg_write = '0;
    req_rd        = '0;
    req_data      = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 1'b1;
    alu_wb_inf.do_branch = 1'b1;
    alu_wb_inf.branch_target = 32'hFFFF_0000;
    alu_wb_inf.icache_invalidate = 1'b1;
    alu_wb_inf.register_write = 1'b1;
    alu_wb_inf.rd = 5'd9;
    alu_wb_inf.exe_result = 32'hCAFE_F00D;
    req_valid = 3'b111;
    req_reg_write = 3'b111;
    req_rd = {5'd12, 5'd11, 5'd10};
    req_data = {32'hC, 32'hB, 32'hA};
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if ({wb_reg_write, wb_do_branch, wb_icache_invalidate, ix_stall} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000",
        {wb_reg_write, wb_do_branch, wb_icache_invalidate, ix_stall});
    end
    n_checks++;
    if ({wb_rd, wb_result, wb_branch_target} !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_data got rd=%0d res=%h tgt=%h want 0",
        wb_rd, wb_result, wb_branch_target);
    end
    n_checks++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 000", req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    alu_valid = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_first_grant got %b want 001", req_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_rd !== 5'd10 || wb_reg_write !== 1'b1 || wb_result !== 32'hA) begin
      n_fail++;
      $display("FAIL reset_first_wb got rd=%0d we=%b res=%h want 10 1 a",
        wb_rd, wb_reg_write, wb_result);
    end
  endtask

  task automatic test_alu_priority();
    do_reset();
    alu_valid = 1'b1;
    alu_wb_inf.register_write = 1'b1;
    alu_wb_inf.rd = 5'd5;
    alu_wb_inf.exe_result = 32'h1234;
    req_valid = 3'b111;
    req_reg_write = 3'b111;
    req_rd = {5'd12, 5'd11, 5'd10};
    #1;
    n_checks++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL alu_prio_ready got %b want 000", req_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_reg_write !== 1'b1 || wb_rd !== 5'd5 || wb_result !== 32'h1234
        || wb_do_branch !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_prio_wb got we=%b rd=%0d res=%h br=%b want 1 5 1234 0",
        wb_reg_write, wb_rd, wb_result, wb_do_branch);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_rdy [4];
    logic [4:0]  exp_rd  [4];
    logic [31:0] exp_dat [4];
    exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_rd  = '{5'd10, 5'd11, 5'd12, 5'd10};
    exp_dat = '{32'h1110, 32'h2220, 32'h3330, 32'h1110};
    do_reset();
    req_valid = 3'b111;
    req_reg_write = 3'b111;
    req_rd = {5'd12, 5'd11, 5'd10};
    req_data = {32'h3330, 32'h2220, 32'h1110};
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (req_ready !== exp_rdy[k]) begin
        n_fail++;
        $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, exp_rdy[k]);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (wb_rd !== exp_rd[k] || wb_result !== exp_dat[k] || wb_reg_write !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_wb[%0d] got rd=%0d res=%h we=%b want %0d %h 1",
          k, wb_rd, wb_result, wb_reg_write, exp_rd[k], exp_dat[k]);
      end
      @(negedge clk);
    end
    req_valid = 3'b101;
    #1;
    n_checks++;
    if (req_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL rr_skip got %b want 100", req_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL rr_wrap got %b want 001", req_ready);
    end
    @(negedge clk);
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_reg_write !== 1'b0 || wb_do_branch !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_idle got we=%b br=%b want 0 0", wb_reg_write, wb_do_branch);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    alu_valid = 1'b1;
    alu_wb_inf.register_write = 1'b1;
    alu_wb_inf.rd = 5'd1;
    alu_wb_inf.exe_result = 32'h1;
    req_valid[WB_REQ_DIV] = 1'b1;
    req_reg_write[WB_REQ_DIV] = 1'b1;
    req_rd[5*WB_REQ_DIV +: 5] = 5'd7;
    req_data[32*WB_REQ_DIV +: 32] = 32'hDEAD;
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (ix_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_early got %b want 0", ix_stall);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (ix_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_rise got %b want 1", ix_stall);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (ix_stall !== 1'b1 || dut.r_starve_cnt !== 4'd8) begin
      n_fail++;
      $display("FAIL starve_sat got stall=%b cnt=%0d want 1 8",
        ix_stall, dut.r_starve_cnt);
    end
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL starve_grant got %b want 010", req_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_rd !== 5'd7 || wb_result !== 32'hDEAD || wb_reg_write !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_wb got rd=%0d res=%h we=%b want 7 dead 1",
        wb_rd, wb_result, wb_reg_write);
    end
    n_checks++;
    if (ix_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_clear got %b want 0", ix_stall);
    end
  endtask

  task automatic test_branch_x0();
    do_reset();
    alu_valid = 1'b1;
    alu_wb_inf.do_branch = 1'b1;
    alu_wb_inf.branch_target = 32'h80;
    alu_wb_inf.register_write = 1'b1;
    alu_wb_inf.rd = 5'd0;
    alu_wb_inf.exe_result = 32'h55;
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_do_branch !== 1'b1 || wb_branch_target !== 32'h80 || wb_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_wb got br=%b tgt=%h we=%b want 1 80 0",
        wb_do_branch, wb_branch_target, wb_reg_write);
    end
    @(negedge clk);
    alu_valid = 1'b0;
    alu_wb_inf = '0;
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_do_branch !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_one_cycle got %b want 0", wb_do_branch);
    end
    @(negedge clk);
    req_valid[WB_REQ_LSU] = 1'b1;
    req_reg_write[WB_REQ_LSU] = 1'b1;
    req_rd[5*WB_REQ_LSU +: 5] = 5'd0;
    req_data[32*WB_REQ_LSU +: 32] = 32'h4242;
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_reg_write !== 1'b0 || wb_result !== 32'h4242) begin
      n_fail++;
      $display("FAIL req_x0 got we=%b res=%h want 0 4242", wb_reg_write, wb_result);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_fence_i();
    do_reset();
    alu_valid = 1'b1;
    alu_wb_inf.icache_invalidate = 1'b1;
    alu_wb_inf.register_write = 1'b1;
    alu_wb_inf.rd = 5'd3;
    alu_wb_inf.exe_result = 32'h77;
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_icache_invalidate !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 5'd3) begin
      n_fail++;
      $display("FAIL fence_wb got inv=%b we=%b rd=%0d want 1 1 3",
        wb_icache_invalidate, wb_reg_write, wb_rd);
    end
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_icache_invalidate !== 1'b0 || wb_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL fence_one_cycle got inv=%b we=%b want 0 0",
        wb_icache_invalidate, wb_reg_write);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    alu_valid = 1'b1;
    req_valid = 3'b001;
    req_reg_write = 3'b001;
    req_rd = {5'd0, 5'd0, 5'd4};
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (ix_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre got %b want 1", ix_stall);
    end
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_ready got %b want 000", req_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (ix_stall !== 1'b0 || dut.r_starve_cnt !== 4'd0 || wb_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear got stall=%b cnt=%0d we=%b want 0 0 0",
        ix_stall, dut.r_starve_cnt, wb_reg_write);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_alu_priority();
    test_round_robin();
    test_starvation();
    test_branch_x0();
    test_fence_i();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Schedules the single writeback slot: the register-file write port plus the branch redirect.
- Requesters: the ALU, which is fixed-latency with no backpressure, and NUM_REQ long-latency units (MUL, DIV, LSU, ...), each using a valid/ready handshake.
- The ALU always wins the slot. Long-latency units share the leftover slots round-robin.
- A starvation counter stalls IX issue so that a waiting long-latency result is guaranteed a slot.

Parameters:
- NUM_REQ, 3, number of long-latency requesters (index 0 = MUL, 1 = DIV, 2 = LSU).
- STARVE_LIMIT, 8, consecutive denied cycles before ix_stall asserts (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result valid this cycle
- alu_wb_inf  in  alu_wb_inf_t  do_branch, branch_target, icache_invalidate, register_write, rd, exe_result
- req_valid  in  NUM_REQ  long-latency result valid
- req_reg_write  in  NUM_REQ  result writes rd
- req_rd  in  5*NUM_REQ  destination register, packed, slot i at [5i+4:5i]
- req_data  in  32*NUM_REQ  result, packed, slot i at [32i+31:32i]
- req_ready  out  NUM_REQ  grant; combinational, at most one bit set
- wb_reg_write  out  1  register-file write enable
- wb_rd  out  5  register-file write address
- wb_result  out  32  register-file write data
- wb_do_branch  out  1  redirect fetch; also the flush to IX/ALU
- wb_branch_target  out  32  redirect PC
- wb_icache_invalidate  out  1  fence.i seen at writeback
- ix_stall  out  1  block IX issue to the ALU

Behaviour:
- Reset: all outputs 0; rr_ptr=0; starve_cnt=0; ix_stall=0. A reset mid-operation drops any in-flight transfer; requesters hold valid through reset.

Slot ownership, each cycle:
- alu_valid=1:
  - ALU owns the slot; all req_ready=0.
  - Next cycle:
    - wb_reg_write = register_write && rd≠0
    - wb_rd = rd, wb_result = exe_result
    - wb_do_branch = do_branch
    - wb_branch_target = branch_target
    - wb_icache_invalidate = icache_invalidate
- alu_valid=0:
  - Grant the first i with req_valid[i], searching from rr_ptr upward with wrap-around.
  - req_ready[i]=1 combinationally; the transfer occurs on valid&&ready.
  - Next cycle: wb_reg_write = req_reg_write[i] && rd≠0, wb_rd and wb_result from slot i, wb_do_branch=0, wb_icache_invalidate=0.
  - rr_ptr ← (i+1) mod NUM_REQ.
- No grant: wb_reg_write=0 and wb_do_branch=0 next cycle. rr_ptr holds. wb_rd, wb_result and wb_branch_target hold their last values (don't-care).

Latency and ordering:
- Latency is exactly 1 cycle, input to registered output.
- wb_do_branch is high for exactly one cycle per taken ALU branch or fence.i.
- Requesters are never flushed by the arbiter; in-order issue makes their results older than any ALU branch.

Starvation:
- pending = |req_valid && alu_valid.
- If pending, starve_cnt increments, saturating at STARVE_LIMIT; otherwise it clears to 0.
- ix_stall is registered:
  - Set when starve_cnt reaches STARVE_LIMIT-1 while pending.
  - Cleared the cycle after any long-latency transfer.
  - Cleared when |req_valid=0.
- Once ix_stall is seen, alu_valid drops one cycle later, guaranteeing a grant within 2 cycles.
- ix_stall and wb_do_branch may both be high; IX honours both.

Decomposition:
- Shared defines package holds:
  - alu_wb_inf_t (existing)
  - new wb_req_t {register_write, rd[4:0], data[31:0]}
  - localparam WB_REQ_MUL=0, WB_REQ_DIV=1, WB_REQ_LSU=2
- One sub-module: rr_arbiter (NUM_REQ request vector + rr_ptr → one-hot grant, grant index). It is combinational; the pointer register lives in wb_arbiter.

Test Plan:
- Reset test: hold rst 2 cycles with all inputs active → all outputs 0. First grant after release goes to index 0.
- ALU priority: alu_valid=1 (rd=5, exe_result=0x1234, register_write=1) with req_valid=3'b111 → req_ready=0. Next cycle wb_reg_write=1, wb_rd=5, wb_result=0x1234.
- Round-robin: alu_valid=0, req_valid=3'b111 held 3 cycles → grants 0,1,2 in order. wb_rd follows req_rd of slots 0,1,2.
- Starvation: alu_valid=1 continuously, req_valid[1]=1 (rd=7, data=0xDEAD) → ix_stall rises after 8 cycles. Driver drops alu_valid next cycle → DIV granted, wb_rd=7, wb_result=0xDEAD; ix_stall clears the following cycle.
- Branch and x0:
  - ALU do_branch=1, branch_target=0x80, register_write=1, rd=0 → wb_do_branch=1 for one cycle, wb_branch_target=0x80, wb_reg_write=0.
  - fence.i (icache_invalidate=1) → wb_icache_invalidate=1 for one cycle.
- Reset mid-stall: assert rst while ix_stall=1 → ix_stall=0 and starve_cnt=0 next cycle.
